// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Holds the PC,
//   selects the next PC from a 2-bit source code, fetches from a wait-state
//   instruction memory and hands {instr, pc, pc+4, valid} to decode while
//   honouring hazard stall/flush controls.
//
//   Optional feature macro: FETCH_MISALIGN_CHK_EN
//     defined   : a redirect target with [1:0] != 0 sets sticky misalign_o,
//                 freezes the PC, drops imem_req and keeps IF/ID bubbled.
//     undefined : redirect targets are word-aligned by clearing bits [1:0].
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall_f             hold PC and IF/ID contents
//   flush_d             load a bubble into IF/ID
//   pc_src              0 pc+4, 1 pc_target, 2 alu_result (jalr), 3 hold PC
//   pc_target           branch/jal target
//   alu_result          jalr target
//   imem_req/imem_addr  fetch request and address (address = current PC)
//   imem_ready/rdata    memory response for imem_addr this cycle
//   instr_d, pc_d,
//   pcplus4_d, valid_d  IF/ID register contents
//   fetch_busy          waiting on memory (stall request to hazard unit)
//   misalign_o          sticky misaligned-target flag (macro builds only)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        flush_d,
   input  logic [1:0]  pc_src,
   input  logic [31:0] pc_target,
   input  logic [31:0] alu_result,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pcplus4_d,
   output logic        valid_d,
   output logic        fetch_busy
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic        misalign_o
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] hold_reg, hold_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc_d_reg, pc_d_next;
   logic [31:0] pcplus4_d_reg, pcplus4_d_next;
   logic        valid_reg, valid_next;

   logic        redirect;
   logic [31:0] raw_target;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        bad_target;
   logic        frozen;
   logic        bubble;
   logic        load_en;
   logic [31:0] load_word;

   // Redirect source decode; jalr target always has bit 0 cleared.
   always_comb begin
      redirect   = (pc_src == 2'd1) || (pc_src == 2'd2);
      raw_target = (pc_src == 2'd1) ? pc_target : (alu_result & ~32'd1);
   end

   assign pc_plus4 = pc_reg + 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_reg;

   assign target     = raw_target;
   assign bad_target = redirect && (raw_target[1:0] != 2'b00);
   assign frozen     = misalign_reg;
   assign misalign_o = misalign_reg;

   // Sticky: once set, only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_reg <= 1'b0;
      end else if (bad_target) begin
         misalign_reg <= 1'b1;
      end
   end
`else
   assign target     = raw_target & ~32'd3;
   assign bad_target = 1'b0;
   assign frozen     = 1'b0;
`endif

   // Next-state and IF/ID update. A bubble request from any source (redirect,
   // wait state, pc_src=3, flush) is applied last so it always wins.
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      hold_next      = hold_reg;
      instr_next     = instr_reg;
      pc_d_next      = pc_d_reg;
      pcplus4_d_next = pcplus4_d_reg;
      valid_next     = valid_reg;
      bubble         = 1'b0;
      load_en        = 1'b0;
      load_word      = imem_rdata;

      if (frozen || bad_target) begin
         bubble = 1'b1;
      end else if (redirect) begin
         // Redirect beats stall and any same-cycle response; hold buffer dropped.
         pc_next    = target;
         state_next = FETCH;
         bubble     = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next = FETCH;
            end
            FETCH: begin
               if (imem_ready) begin
                  if (stall_f) begin
                     // Park the word so it is delivered exactly once on release.
                     hold_next  = imem_rdata;
                     state_next = HOLD;
                  end else if (pc_src == 2'd3) begin
                     // PC held: this word is refetched next cycle.
                     bubble = 1'b1;
                  end else begin
                     load_en   = 1'b1;
                     load_word = imem_rdata;
                     pc_next   = pc_plus4;
                  end
               end else if (!stall_f) begin
                  bubble = 1'b1;
               end
            end
            HOLD: begin
               if (!stall_f) begin
                  state_next = FETCH;
                  if (pc_src == 2'd3) begin
                     bubble = 1'b1;
                  end else begin
                     load_en   = 1'b1;
                     load_word = hold_reg;
                     pc_next   = pc_plus4;
                  end
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end

      if (load_en) begin
         instr_next     = load_word;
         pc_d_next      = pc_reg;
         pcplus4_d_next = pc_plus4;
         valid_next     = 1'b1;
      end

      if (flush_d) begin
         bubble = 1'b1;
      end

      if (bubble) begin
         instr_next     = NOP_INSTR;
         pc_d_next      = 32'd0;
         pcplus4_d_next = 32'd0;
         valid_next     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_VECTOR;
         hold_reg      <= 32'd0;
         instr_reg     <= NOP_INSTR;
         pc_d_reg      <= 32'd0;
         pcplus4_d_reg <= 32'd0;
         valid_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         hold_reg      <= hold_next;
         instr_reg     <= instr_next;
         pc_d_reg      <= pc_d_next;
         pcplus4_d_reg <= pcplus4_d_next;
         valid_reg     <= valid_next;
      end
   end

   assign imem_req   = (state_reg == FETCH) && !frozen;
   assign imem_addr  = pc_reg;
   assign fetch_busy = (state_reg == FETCH) && !imem_ready && !frozen;
   assign instr_d    = instr_reg;
   assign pc_d       = pc_d_reg;
   assign pcplus4_d  = pcplus4_d_reg;
   assign valid_d    = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Stimulus pushes each instruction word it
//   expects to reach IF/ID into a scoreboard queue; a monitor pops and compares
//   whenever IF/ID presents a freshly loaded valid word (valid_d high after an
//   edge with stall_f low). Control-path outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RV  = 32'hBFC0_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        stall_f    = 1'b0;
   logic        flush_d    = 1'b0;
   logic [1:0]  pc_src     = 2'd0;
   logic [31:0] pc_target  = 32'd0;
   logic [31:0] alu_result = 32'd0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'd0;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pcplus4_d;
   logic        valid_d;
   logic        fetch_busy;

   fetch_stage #(
      .RESET_VECTOR (RV),
      .NOP_INSTR    (NOP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_f    (stall_f),
      .flush_d    (flush_d),
      .pc_src     (pc_src),
      .pc_target  (pc_target),
      .alu_result (alu_result),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .instr_d    (instr_d),
      .pc_d       (pc_d),
      .pcplus4_d  (pcplus4_d),
      .valid_d    (valid_d),
      .fetch_busy (fetch_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic expect_word(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
      exp_t e;
      e.instr = i;
      e.pc    = p;
      e.pc4   = p4;
      sb.push_back(e);
   endtask

   task automatic drive(input logic rdy, input logic [31:0] rd, input logic st,
                        input logic fl, input logic [1:0] src,
                        input logic [31:0] tgt, input logic [31:0] alu);
      imem_ready = rdy;
      imem_rdata = rd;
      stall_f    = st;
      flush_d    = fl;
      pc_src     = src;
      pc_target  = tgt;
      alu_result = alu;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},     {31'd0, imem_req},   32'd0);
      chk({tag, "_busy"},    {31'd0, fetch_busy}, 32'd0);
      chk({tag, "_valid"},   {31'd0, valid_d},    32'd0);
      chk({tag, "_instr"},   instr_d,             NOP);
      chk({tag, "_pc_d"},    pc_d,                32'd0);
      chk({tag, "_pc4_d"},   pcplus4_d,           32'd0);
      chk({tag, "_addr"},    imem_addr,           RV);
   endtask

   // Monitor: a new word is in IF/ID when valid_d is high after an unstalled edge.
   initial begin
      logic stall_seen;
      exp_t e;
      forever begin
         @(posedge clk);
         stall_seen = stall_f;
         @(negedge clk);
         if (rst_n && !stall_seen && valid_d) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected: got instr %h pc %h, required no word", instr_d, pc_d);
            end else begin
               e = sb.pop_front();
               chk("sb_instr", instr_d,   e.instr);
               chk("sb_pc",    pc_d,      e.pc);
               chk("sb_pc4",   pcplus4_d, e.pc4);
            end
         end
      end
   end

   // Watchdog: the stimulus is a fixed sequence, this only guards against a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      #1 chk("idle_req", {31'd0, imem_req}, 32'd0);

      // First fetch at the reset vector, ready immediately
      @(negedge clk);
      chk("fetch_req",  {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, RV);
      drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      expect_word(32'h0050_0093, RV, RV + 32'd4);
      @(negedge clk);
      chk("seq_addr", imem_addr, RV + 32'd4);

      // Branch redirect to 0x40; same-cycle response must be discarded
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd1, 32'h40, 32'd0);
      @(negedge clk);
      chk("redir_addr",   imem_addr, 32'h40);
      chk("redir_bubble", {31'd0, valid_d}, 32'd0);

      // Two wait states at 0x40
      drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      #1 chk("wait_busy1", {31'd0, fetch_busy}, 32'd1);
      @(negedge clk);
      chk("wait_addr1",  imem_addr, 32'h40);
      chk("wait_bub1",   {31'd0, valid_d}, 32'd0);
      chk("wait_busy2",  {31'd0, fetch_busy}, 32'd1);
      @(negedge clk);
      chk("wait_addr2",  imem_addr, 32'h40);
      chk("wait_bub2",   {31'd0, valid_d}, 32'd0);
      drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      expect_word(32'h1111_1111, 32'h40, 32'h44);
      #1 chk("wait_done_busy", {31'd0, fetch_busy}, 32'd0);
      @(negedge clk);
      chk("wait_next_addr", imem_addr, 32'h44);

      // Back to 0x40, then stall exactly when the response arrives
      drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 32'h40, 32'd0);
      @(negedge clk);
      chk("re40_addr", imem_addr, 32'h40);
      drive(1'b1, 32'h0000_00AA, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
      expect_word(32'h0000_00AA, 32'h40, 32'h44);
      @(negedge clk);
      chk("hold_req",   {31'd0, imem_req}, 32'd0);
      chk("hold_valid", {31'd0, valid_d}, 32'd0);
      chk("hold_addr",  imem_addr, 32'h40);
      drive(1'b1, 32'h0000_00BB, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("hold_req2", {31'd0, imem_req}, 32'd0);
      drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("release_addr", imem_addr, 32'h44);
      chk("release_req",  {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      chk("no_dup_valid", {31'd0, valid_d}, 32'd0);

      // Redirect while stalled wins over stall and the response
      drive(1'b1, 32'h0000_00CC, 1'b1, 1'b0, 2'd1, 32'h100, 32'd0);
      @(negedge clk);
      chk("stall_redir_addr",  imem_addr, 32'h100);
      chk("stall_redir_valid", {31'd0, valid_d}, 32'd0);

      // jalr target with bit 0 set
      drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd2, 32'd0, 32'h205);
      @(negedge clk);
      chk("jalr_addr", imem_addr, 32'h204);

      // pc_src=3 holds PC and bubbles even with a response present
      drive(1'b1, 32'h0000_0033, 1'b0, 1'b0, 2'd3, 32'd0, 32'd0);
      @(negedge clk);
      chk("hold_pc_addr",  imem_addr, 32'h204);
      chk("hold_pc_valid", {31'd0, valid_d}, 32'd0);
      drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      expect_word(32'h4444_4444, 32'h204, 32'h208);
      @(negedge clk);
      chk("refetch_next_addr", imem_addr, 32'h208);

      // Flush: bubble in IF/ID, PC still advances
      drive(1'b1, 32'h0000_0055, 1'b0, 1'b1, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("flush_valid", {31'd0, valid_d}, 32'd0);
      chk("flush_instr", instr_d, NOP);
      chk("flush_addr",  imem_addr, 32'h20C);

      // Wrap-around at the top of the address space
      drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 32'hFFFF_FFFC, 32'd0);
      @(negedge clk);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      drive(1'b1, 32'h0000_0066, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      expect_word(32'h0000_0066, 32'hFFFF_FFFC, 32'd0);
      @(negedge clk);
      chk("wrap_next_addr", imem_addr, 32'd0);

      // Misaligned branch target is word-aligned
      drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 32'h103, 32'd0);
      @(negedge clk);
      chk("align_addr", imem_addr, 32'h100);
      drive(1'b1, 32'h0000_0077, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      expect_word(32'h0000_0077, 32'h100, 32'h104);
      @(negedge clk);
      chk("align_next_addr", imem_addr, 32'h104);

      // Waiting on memory with a valid word held, then async reset mid-wait
      drive(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("pre_rst_busy",  {31'd0, fetch_busy}, 32'd1);
      chk("pre_rst_valid", {31'd0, valid_d}, 32'd1);
      chk("pre_rst_instr", instr_d, 32'h0000_0077);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midrst");

      @(negedge clk);
      @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
